// File: rtl/grid_adventure_fsm.sv
// Grid adventure FSM: walk a GRID_W x GRID_H grid, grab the sword, then face the den.
// Optional trap cell is enabled with `define GRID_ADVENTURE_TRAP_EN.
module grid_adventure_fsm #(
    parameter int unsigned GRID_W    = 3,
    parameter int unsigned GRID_H    = 2,
    parameter int unsigned START_X   = 0,
    parameter int unsigned START_Y   = 0,
    parameter int unsigned STASH_X   = 0,
    parameter int unsigned STASH_Y   = 1,
    parameter int unsigned DEN_X     = 2,
    parameter int unsigned DEN_Y     = 1,
`ifdef GRID_ADVENTURE_TRAP_EN
    parameter int unsigned TRAP_X    = 1,
    parameter int unsigned TRAP_Y    = 0,
`endif
    parameter int unsigned WRAP      = 0,
    parameter int unsigned MAX_MOVES = 8,
    parameter int unsigned XW        = (GRID_W > 1) ? $clog2(GRID_W) : 1,
    parameter int unsigned YW        = (GRID_H > 1) ? $clog2(GRID_H) : 1,
    parameter int unsigned MW        = (MAX_MOVES > 0) ? $clog2(MAX_MOVES + 1) : 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          restart,
    input  logic          n,
    input  logic          s,
    input  logic          e,
    input  logic          w,
    output logic [XW-1:0] pos_x,
    output logic [YW-1:0] pos_y,
    output logic          sw,
    output logic          win,
    output logic          d,
    output logic          bump,
`ifdef GRID_ADVENTURE_TRAP_EN
    output logic          trap,
`endif
    output logic [MW-1:0] moves
);

    typedef enum logic [1:0] {StExplore, StDen, StVault, StGraveyard} state_e;

    state_e        state;
    logic          valid;
    logic          off_grid;
    logic          blocked;
    logic          budget_out;
    logic          at_stash;
    logic          at_den;
    logic [XW-1:0] tgt_x;
    logic [YW-1:0] tgt_y;
`ifdef GRID_ADVENTURE_TRAP_EN
    logic          at_trap;
`endif

    // Target cell for the commanded step; off-grid targets are pre-wrapped.
    always_comb begin
        valid    = $onehot({n, s, e, w});
        tgt_x    = pos_x;
        tgt_y    = pos_y;
        off_grid = 1'b0;
        if (n) begin
            if (pos_y == '0) begin
                off_grid = 1'b1;
                tgt_y    = YW'(GRID_H - 1);
            end else begin
                tgt_y = pos_y - YW'(1);
            end
        end else if (s) begin
            if (pos_y == YW'(GRID_H - 1)) begin
                off_grid = 1'b1;
                tgt_y    = '0;
            end else begin
                tgt_y = pos_y + YW'(1);
            end
        end else if (e) begin
            if (pos_x == XW'(GRID_W - 1)) begin
                off_grid = 1'b1;
                tgt_x    = '0;
            end else begin
                tgt_x = pos_x + XW'(1);
            end
        end else if (w) begin
            if (pos_x == '0) begin
                off_grid = 1'b1;
                tgt_x    = XW'(GRID_W - 1);
            end else begin
                tgt_x = pos_x - XW'(1);
            end
        end
        blocked    = off_grid && (WRAP == 0);
        budget_out = (MAX_MOVES != 0) && (moves == MW'(MAX_MOVES));
        at_stash   = (tgt_x == XW'(STASH_X)) && (tgt_y == YW'(STASH_Y));
        at_den     = (tgt_x == XW'(DEN_X)) && (tgt_y == YW'(DEN_Y));
`ifdef GRID_ADVENTURE_TRAP_EN
        at_trap    = (tgt_x == XW'(TRAP_X)) && (tgt_y == YW'(TRAP_Y));
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= StExplore;
            pos_x <= XW'(START_X);
            pos_y <= YW'(START_Y);
            sw    <= 1'b0;
            win   <= 1'b0;
            d     <= 1'b0;
            bump  <= 1'b0;
            moves <= '0;
`ifdef GRID_ADVENTURE_TRAP_EN
            trap  <= 1'b0;
`endif
        end else if (restart) begin
            state <= StExplore;
            pos_x <= XW'(START_X);
            pos_y <= YW'(START_Y);
            sw    <= 1'b0;
            win   <= 1'b0;
            d     <= 1'b0;
            bump  <= 1'b0;
            moves <= '0;
`ifdef GRID_ADVENTURE_TRAP_EN
            trap  <= 1'b0;
`endif
        end else begin
            bump <= 1'b0;
            case (state)
                StExplore: begin
                    if (valid) begin
                        if (blocked) begin
                            bump <= 1'b1;
                        end else if (budget_out) begin
                            state <= StGraveyard;
                            d     <= 1'b1;
                        end else begin
                            pos_x <= tgt_x;
                            pos_y <= tgt_y;
                            moves <= moves + MW'(1);
                            if (at_stash) sw <= 1'b1;
`ifdef GRID_ADVENTURE_TRAP_EN
                            trap <= at_trap;
                            // The sword absorbs the trap; without it the trap is fatal.
                            if (at_trap) begin
                                if (sw) begin
                                    sw <= 1'b0;
                                end else begin
                                    state <= StGraveyard;
                                    d     <= 1'b1;
                                end
                            end
`endif
                            if (at_den) state <= StDen;
                        end
                    end
                end
                StDen: begin
                    if (sw) begin
                        state <= StVault;
                        win   <= 1'b1;
                    end else begin
                        state <= StGraveyard;
                        d     <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_grid_adventure_fsm.sv
// Scoreboard bench: two configurations driven in lockstep, checked against a grid model.
module tb_grid_adventure_fsm;

    localparam int GW = 3;
    localparam int GH = 2;
    localparam int DX = 2;
    localparam int DY = 1;
    localparam int M_EXPLORE = 0;
    localparam int M_DEN = 1;
    localparam int M_VAULT = 2;
    localparam int M_DEAD = 3;

    typedef struct {
        int x;
        int y;
        int sw;
        int mode;
        int moves;
        int bump;
    } mdl_t;

    typedef struct {
        mdl_t a;
        mdl_t b;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n, restart, n, s, e, w;
    logic [1:0] px0, px1;
    logic [0:0] py0, py1;
    logic sw0, win0, d0, bump0, sw1, win1, d1, bump1;
    logic [3:0] mv0;
    logic [1:0] mv1;

    int total = 0;
    int bad = 0;
    exp_t q[$];
    mdl_t ma, mb;

    always #5 clk = ~clk;

    grid_adventure_fsm dut0 (
        .clk(clk), .reset_n(reset_n), .restart(restart),
        .n(n), .s(s), .e(e), .w(w),
        .pos_x(px0), .pos_y(py0), .sw(sw0), .win(win0), .d(d0), .bump(bump0), .moves(mv0)
    );

    grid_adventure_fsm #(
        .WRAP(1), .MAX_MOVES(3), .STASH_X(1), .STASH_Y(1)
    ) dut1 (
        .clk(clk), .reset_n(reset_n), .restart(restart),
        .n(n), .s(s), .e(e), .w(w),
        .pos_x(px1), .pos_y(py1), .sw(sw1), .win(win1), .d(d1), .bump(bump1), .moves(mv1)
    );

    function automatic mdl_t reset_m();
        mdl_t r;
        r.x = 0; r.y = 0; r.sw = 0; r.mode = M_EXPLORE; r.moves = 0; r.bump = 0;
        return r;
    endfunction

    // cmd bits are {n, s, e, w}
    function automatic mdl_t step(mdl_t m, bit [3:0] cmd, bit rs, int wrap, int maxm,
                                  int sx, int sy);
        mdl_t r;
        int tx, ty;
        bit off;
        r = m;
        r.bump = 0;
        if (rs) return reset_m();
        if (m.mode == M_DEN) begin
            r.mode = (m.sw != 0) ? M_VAULT : M_DEAD;
        end else if (m.mode == M_EXPLORE && $countones(cmd) == 1) begin
            tx = m.x + (cmd[1] ? 1 : 0) - (cmd[0] ? 1 : 0);
            ty = m.y + (cmd[2] ? 1 : 0) - (cmd[3] ? 1 : 0);
            off = (tx < 0) || (tx >= GW) || (ty < 0) || (ty >= GH);
            if (off && wrap == 0) begin
                r.bump = 1;
            end else if (maxm != 0 && m.moves == maxm) begin
                r.mode = M_DEAD;
            end else begin
                r.x = (tx + GW) % GW;
                r.y = (ty + GH) % GH;
                r.moves = m.moves + 1;
                if (r.x == sx && r.y == sy) r.sw = 1;
                if (r.x == DX && r.y == DY) r.mode = M_DEN;
            end
        end
        return r;
    endfunction

    task automatic chk(string nm, mdl_t m, int x, int y, int sw_, int win_, int d_,
                       int bump_, int mv);
        int ew, ed;
        ew = (m.mode == M_VAULT) ? 1 : 0;
        ed = (m.mode == M_DEAD) ? 1 : 0;
        total++;
        if (x != m.x || y != m.y || sw_ != m.sw || win_ != ew || d_ != ed ||
            bump_ != m.bump || mv != m.moves) begin
            bad++;
            $display("FAIL %s t=%0t: got pos=(%0d,%0d) sw=%0d win=%0d d=%0d bump=%0d moves=%0d; expected pos=(%0d,%0d) sw=%0d win=%0d d=%0d bump=%0d moves=%0d",
                     nm, $time, x, y, sw_, win_, d_, bump_, mv,
                     m.x, m.y, m.sw, ew, ed, m.bump, m.moves);
        end
    endtask

    task automatic chk_both(string nm, exp_t ex);
        chk({nm, "_cfg0"}, ex.a, int'(px0), int'(py0), int'(sw0), int'(win0), int'(d0),
            int'(bump0), int'(mv0));
        chk({nm, "_cfg1"}, ex.b, int'(px1), int'(py1), int'(sw1), int'(win1), int'(d1),
            int'(bump1), int'(mv1));
    endtask

    task automatic push_exp();
        exp_t ex;
        ex.a = ma;
        ex.b = mb;
        q.push_back(ex);
    endtask

    task automatic cyc(bit [3:0] cmd, bit rs);
        @(negedge clk);
        reset_n = 1'b1;
        {n, s, e, w} = cmd;
        restart = rs;
        ma = step(ma, cmd, rs, 0, 8, 0, 1);
        mb = step(mb, cmd, rs, 1, 3, 1, 1);
        push_exp();
    endtask

    task automatic async_reset();
        exp_t ex;
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        {n, s, e, w} = 4'b0000;
        restart = 1'b0;
        #1;
        ma = reset_m();
        mb = reset_m();
        ex.a = ma;
        ex.b = mb;
        chk_both("async_reset", ex);
        push_exp();
    endtask

    localparam bit [3:0] CN = 4'b1000, CS = 4'b0100, CE = 4'b0010, CW = 4'b0001, C0 = 4'b0000;

    initial begin : monitor
        exp_t ex;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                ex = q.pop_front();
                chk_both("scoreboard", ex);
            end
        end
    end

    initial begin : stimulus
        bit [3:0] cmd;
        reset_n = 1'b0;
        restart = 1'b0;
        {n, s, e, w} = 4'b0000;
        ma = reset_m();
        mb = reset_m();
        push_exp();
        cyc(C0, 0);
        // win path via the stash
        cyc(CE, 0); cyc(CS, 0); cyc(CW, 0); cyc(CE, 0); cyc(CE, 0);
        cyc(C0, 0); cyc(C0, 0); cyc(CN, 0);
        cyc(C0, 1);
        // death path without the sword
        cyc(CE, 0); cyc(CS, 0); cyc(CE, 0); cyc(C0, 0); cyc(CW, 0); cyc(CN, 0);
        cyc(C0, 1);
        // wall bump / wrap and a multi-command
        cyc(CW, 0); cyc(C0, 0); cyc(CN | CE, 0); cyc(C0, 0);
        cyc(C0, 1);
        // budget exhaustion on the second configuration
        cyc(CE, 0); cyc(CW, 0); cyc(CE, 0); cyc(CW, 0); cyc(CE, 0); cyc(C0, 0);
        cyc(C0, 1);
        // asynchronous reset after picking up the sword
        cyc(CE, 0); cyc(CS, 0); cyc(CW, 0);
        async_reset();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 31) == 0) begin
                async_reset();
            end else begin
                if ($urandom_range(0, 3) != 0) cmd = 4'b0001 << $urandom_range(0, 3);
                else cmd = 4'($urandom_range(0, 15));
                cyc(cmd, ($urandom_range(0, 19) == 0));
            end
        end
        cyc(C0, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL queue_drain: got %0d pending entries, expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
